// File: rtl/alu_md_unit.sv
// alu_md_unit: ALU operation decoder plus an iterative RV32M/RV64M
// multiply/divide engine that stalls EX until its result is ready.
//   - Base-ISA ops are decoded combinationally onto operation_o.
//   - M-extension ops run through a shift-add multiplier or a restoring
//     divider, one step per clock, and deliver a one-cycle result strobe.
// Optional build macro: ALU_MD_EARLY_OUT_EN -- MUL-family ops finish as soon
// as the remaining multiplier bits are all zero.
module alu_md_unit #(
  parameter int XLEN = 32,
  parameter int OP_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic [OP_W-1:0] operation_o,
  output logic            ready_o,
  output logic            stall_o,
  output logic [XLEN-1:0] result_o,
  output logic            result_valid_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_XOR   = 4'b0011,
    OP_SLL   = 4'b0100,
    OP_SRL   = 4'b0101,
    OP_SUB   = 4'b0110,
    OP_SRA   = 4'b0111,
    OP_BRCMP = 4'b1000,
    OP_SLT   = 4'b1001,
    OP_SLTU  = 4'b1010
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        f3_q, f3_d;        // Funct3[1:0]; bit 2 is implied by MUL/DIV state
  logic              neg_res_q, neg_res_d;   // negate product / quotient
  logic              neg_rem_q, neg_rem_d;   // negate remainder
  logic [2*XLEN-1:0] acc_q, acc_d;           // product accumulator
  logic [2*XLEN-1:0] mcand_q, mcand_d;       // multiplicand, shifted left each step
  logic [XLEN-1:0]   opb_q, opb_d;           // multiplier shift register / divisor
  logic [XLEN-1:0]   rem_q, rem_d;           // partial remainder
  logic [XLEN-1:0]   quo_q, quo_d;           // dividend bits shifting out, quotient bits in
  logic [XLEN-1:0]   result_q, result_d;

  alu_op_e           op;
  logic              m_op;
  logic              accept;
  logic              sgn_a, sgn_b;
  logic              neg_a, neg_b;
  logic [XLEN-1:0]   mag_a, mag_b;

  // Step datapath temporaries
  logic [2*XLEN-1:0] acc_step, prod;
  logic [XLEN:0]     shifted, diff;
  logic [XLEN-1:0]   rem_step, quo_step, q_fix, r_fix;
  logic              mul_last;

  // Combinational base-ISA decode, independent of the M engine.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    op = OP_ADD;
    case (ALUOp)
      2'b01: op = OP_BRCMP;
      2'b10: begin
        if (Funct7 == 7'b0000000) begin
          case (Funct3)
            3'b000:  op = OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = OP_SRL;
            3'b110:  op = OP_OR;
            default: op = OP_AND;
          endcase
        end else if (Funct7 == 7'b0100000) begin
          if (Funct3 == 3'b000)      op = OP_SUB;
          else if (Funct3 == 3'b101) op = OP_SRA;
        end
      end
      default: op = OP_ADD;
    endcase
  end

  assign operation_o = OP_W'(op);

  assign m_op    = (ALUOp == 2'b10) && (Funct7 == 7'b0000001);
  assign ready_o = (state_q == S_IDLE);
  assign accept  = ready_o && valid_i && m_op && !flush_i;
  assign stall_o = (state_q == S_MUL) || (state_q == S_DIV) || accept;
  assign result_valid_o = (state_q == S_DONE) && !flush_i;
  assign result_o = result_q;

  // Operand signedness from Funct3 and conversion to magnitudes.
  always_comb begin
    if (!Funct3[2]) begin
      sgn_a = (Funct3 != 3'b011);   // MULHU is the only unsigned-rs1 multiply
      sgn_b = !Funct3[1];           // MUL, MULH
    end else begin
      sgn_a = !Funct3[0];           // DIV, REM
      sgn_b = !Funct3[0];
    end
    neg_a = sgn_a && a_i[XLEN-1];
    neg_b = sgn_b && b_i[XLEN-1];
    mag_a = neg_a ? -a_i : a_i;
    mag_b = neg_b ? -b_i : b_i;
  end

  // Next-state and datapath: acceptance, one iteration per cycle, sign fix on the last step.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    f3_d      = f3_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    opb_d     = opb_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    result_d  = result_q;

    acc_step = opb_q[0] ? (acc_q + mcand_q) : acc_q;
    prod     = neg_res_q ? -acc_step : acc_step;

    shifted  = {rem_q, quo_q[XLEN-1]};
    diff     = shifted - {1'b0, opb_q};
    if (!diff[XLEN]) begin
      rem_step = diff[XLEN-1:0];
      quo_step = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_step = shifted[XLEN-1:0];
      quo_step = {quo_q[XLEN-2:0], 1'b0};
    end
    q_fix = neg_res_q ? -quo_step : quo_step;
    r_fix = neg_rem_q ? -rem_step : rem_step;

`ifdef ALU_MD_EARLY_OUT_EN
    mul_last = (cnt_q == '0) || (opb_q[XLEN-1:1] == '0);
`else
    mul_last = (cnt_q == '0);
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          f3_d      = Funct3[1:0];
          neg_res_d = neg_a ^ neg_b;
          neg_rem_d = neg_a;
          cnt_d     = CNT_W'(XLEN - 1);
          if (!Funct3[2]) begin
            acc_d   = '0;
            mcand_d = {{XLEN{1'b0}}, mag_a};
            opb_d   = mag_b;
            state_d = S_MUL;
          end else if (b_i == '0) begin
            // Divide by zero: quotient all-ones, remainder is the dividend.
            result_d = Funct3[1] ? a_i : '1;
            state_d  = S_DONE;
          end else if (!Funct3[0] && (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1)) begin
            // Signed overflow: quotient is the dividend, remainder zero.
            result_d = Funct3[1] ? '0 : a_i;
            state_d  = S_DONE;
          end else begin
            rem_d   = '0;
            quo_d   = mag_a;
            opb_d   = mag_b;
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d   = acc_step;
          mcand_d = mcand_q << 1;
          opb_d   = opb_q >> 1;
          cnt_d   = cnt_q - CNT_W'(1);
          if (mul_last) begin
            result_d = (f3_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
            state_d  = S_DONE;
          end
        end
      end
      S_DIV: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            result_d = f3_q[1] ? r_fix : q_fix;
            state_d  = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;   // S_DONE: strobe lasts one cycle
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      f3_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      opb_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      f3_q      <= f3_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      opb_q     <= opb_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_alu_md_unit.sv
// tb_alu_md_unit: self-checking bench for alu_md_unit (XLEN=32).
// Decode and M-op results are compared against a plain-arithmetic reference
// model; directed cases cover divide special cases, flush and async reset.
module tb_alu_md_unit;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            valid_i;
  logic [1:0]      ALUOp;
  logic [6:0]      Funct7;
  logic [2:0]      Funct3;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            flush_i;
  logic [3:0]      operation_o;
  logic            ready_o;
  logic            stall_o;
  logic [XLEN-1:0] result_o;
  logic            result_valid_o;

  int n_checks = 0;
  int n_pass   = 0;
  logic [XLEN-1:0] last_exp = '0;

  localparam logic [3:0] BASE_OP [8] = '{4'd2, 4'd4, 4'd9, 4'd10, 4'd3, 4'd5, 4'd1, 4'd0};

  alu_md_unit #(.XLEN(XLEN), .OP_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_i        (valid_i),
    .ALUOp          (ALUOp),
    .Funct7         (Funct7),
    .Funct3         (Funct3),
    .a_i            (a_i),
    .b_i            (b_i),
    .flush_i        (flush_i),
    .operation_o    (operation_o),
    .ready_o        (ready_o),
    .stall_o        (stall_o),
    .result_o       (result_o),
    .result_valid_o (result_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference decode.
  function automatic logic [3:0] model_op(input logic [1:0] aluop, input logic [6:0] f7,
                                          input logic [2:0] f3);
    if (aluop == 2'b01) return 4'd8;
    if (aluop != 2'b10) return 4'd2;
    if (f7 == 7'h00) return BASE_OP[f3];
    if (f7 == 7'h20 && f3 == 3'd0) return 4'd6;
    if (f7 == 7'h20 && f3 == 3'd5) return 4'd7;
    return 4'd2;
  endfunction

  // Reference M-op result using 64-bit and int arithmetic.
  function automatic logic [XLEN-1:0] model_res(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
    logic [63:0] sa64, sb64, za64, zb64, p;
    int sa, sb, r;
    sa64 = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    za64 = {32'b0, a};
    zb64 = {32'b0, b};
    sa = $signed(a);
    sb = $signed(b);
    case (f3)
      3'd0: begin p = sa64 * sb64; return p[31:0]; end
      3'd1: begin p = sa64 * sb64; return p[63:32]; end
      3'd2: begin p = sa64 * zb64; return p[63:32]; end
      3'd3: begin p = za64 * zb64; return p[63:32]; end
      3'd4: begin
        if (b == 0) return '1;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        r = sa / sb; return r;
      end
      3'd5: begin if (b == 0) return '1; return a / b; end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
        r = sa % sb; return r;
      end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  // Reference latency in edges, counting the acceptance edge as edge 1.
  function automatic int model_lat(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b);
    logic [XLEN-1:0] mag;
    int hi;
    if (f3[2]) begin
      if (b == 0) return 1;
      if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return XLEN + 1;
    end
`ifdef ALU_MD_EARLY_OUT_EN
    mag = (f3 <= 3'd1 && b[31]) ? (0 - b) : b;
    hi = 0;
    for (int i = 0; i < XLEN; i++) if (mag[i]) hi = i;
    return hi + 2;
`else
    mag = b;
    hi = mag[0];
    return XLEN + 1 + (hi - hi);
`endif
  endfunction

  // Presents one M op right after a rising edge and follows it to its strobe.
  task automatic run_mop(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [XLEN-1:0] exp_res;
    int exp_lat, edges;
    logic busy_ok;
    exp_res = model_res(f3, a, b);
    exp_lat = model_lat(f3, a, b);
    valid_i = 1'b1; ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = f3; a_i = a; b_i = b;
    #1;
    check("accept_stall", {ready_o, stall_o, operation_o}, {1'b1, 1'b1, 4'd2});
    @(posedge clk); edges = 1; #1;
    valid_i = 1'b0;
    busy_ok = 1'b1;
    while (!result_valid_o && edges < XLEN + 8) begin
      if (!stall_o || ready_o) busy_ok = 1'b0;
      @(posedge clk); edges++; #1;
    end
    check("mop_strobe", result_valid_o, 1'b1);
    check("mop_result", result_o, exp_res);
    check("mop_latency", edges, exp_lat);
    check("busy_stall", busy_ok, 1'b1);
    check("done_no_stall", {stall_o, ready_o}, 2'b00);
    last_exp = exp_res;
    @(posedge clk); #1;
    check("back_to_idle", {result_valid_o, ready_o, stall_o}, 3'b010);
  endtask

  task automatic check_decode(input logic [1:0] aluop, input logic [6:0] f7, input logic [2:0] f3);
    logic is_m;
    is_m = (aluop == 2'b10) && (f7 == 7'b0000001);
    valid_i = !is_m; ALUOp = aluop; Funct7 = f7; Funct3 = f3;
    #1;
    check("decode_op", operation_o, model_op(aluop, f7, f3));
    check("decode_no_stall", {stall_o, ready_o}, 2'b01);
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  initial begin
    logic [2:0] f3;
    logic [XLEN-1:0] ra, rb;
    logic seen;
    rst_n = 1'b0; valid_i = 1'b0; ALUOp = 2'b00; Funct7 = '0; Funct3 = '0;
    a_i = '0; b_i = '0; flush_i = 1'b0;
    #3;
    check("reset_state", {ready_o, stall_o, result_valid_o, result_o},
          {1'b1, 1'b0, 1'b0, {XLEN{1'b0}}});
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // Decode: directed then random.
    check_decode(2'b10, 7'h00, 3'b000);
    check_decode(2'b10, 7'h20, 3'b000);
    check_decode(2'b01, 7'h00, 3'b000);
    check_decode(2'b10, 7'h00, 3'b011);
    check_decode(2'b10, 7'h20, 3'b101);
    check_decode(2'b10, 7'h20, 3'b110);
    check_decode(2'b10, 7'h01, 3'b100);
    for (int i = 0; i < 30; i++) begin
      logic [6:0] f7;
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      check_decode(2'($urandom), f7, 3'($urandom));
    end

    // Directed M ops.
    run_mop(3'd0, 32'h0000_0007, 32'hFFFF_FFFD);
    run_mop(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_mop(3'd4, 32'h0000_0064, 32'h0000_0000);
    run_mop(3'd6, 32'h0000_0064, 32'h0000_0000);
    run_mop(3'd5, 32'd100, 32'd7);
    run_mop(3'd7, 32'd100, 32'd7);
    run_mop(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_mop(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    run_mop(3'd4, 32'hFFFF_FFF9, 32'd2);
    run_mop(3'd6, 32'hFFFF_FFF9, 32'd2);
    run_mop(3'd0, 32'd5, 32'd3);
    run_mop(3'd1, 32'h8000_0000, 32'h8000_0000);
    run_mop(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_mop(3'd0, 32'd12345, 32'd0);

    // Flush in IDLE blocks acceptance.
    valid_i = 1'b1; ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'd0; a_i = 32'd9; b_i = 32'd9;
    flush_i = 1'b1;
    #1;
    check("idle_flush_stall", stall_o, 1'b0);
    @(posedge clk); #1;
    check("idle_flush_ready", ready_o, 1'b1);
    valid_i = 1'b0; flush_i = 1'b0;

    // DIVU flushed at edge 10.
    valid_i = 1'b1; Funct3 = 3'd5; a_i = 32'd1000; b_i = 32'd3;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (8) @(posedge clk);
    #1 flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    check("flush_idle", {ready_o, stall_o}, 2'b10);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (result_valid_o) seen = 1'b1;
    end
    check("flush_no_strobe", seen, 1'b0);
    check("flush_result_kept", result_o, last_exp);
    run_mop(3'd0, 32'd11, 32'd13);

    // Asynchronous reset mid-MUL, between edges 5 and 6.
    valid_i = 1'b1; ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'd0; a_i = 32'd7; b_i = 32'h40_0000;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {ready_o, stall_o, result_valid_o, result_o},
          {1'b1, 1'b0, 1'b0, {XLEN{1'b0}}});
    #4 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (result_valid_o || !ready_o) seen = 1'b1;
    end
    check("reset_abort", seen, 1'b0);

    // Randomized M ops with biased operands.
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: ra = '0;
        1: ra = '1;
        2: ra = 32'h8000_0000;
        3: ra = 32'($urandom_range(0, 20));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: rb = '1;
        2: rb = 32'h8000_0000;
        3: rb = 32'($urandom_range(0, 20));
        default: rb = $urandom;
      endcase
      run_mop(f3, ra, rb);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
